axi4_master_bridge: RTL

//  Single-outstanding AXI4 initiator: turns a simple request/response port (IFU/LSU side)

---
 rtl/axi4_master_bridge.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge: single-outstanding AXI4 initiator.
// Converts a simple request/response port into AW/W/B or AR/R traffic.
// It supports single-beat strobed writes and INCR read bursts, with one
// transaction in flight at a time. bid/rid are ignored because only one ID is used.
module axi4_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 8,
  parameter int AXI_ID  = 0
) (
  input  logic              clock,
  input  logic              reset,
  // request / response port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wmask,
  input  logic [7:0]        req_len,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_last,
  output logic              resp_err,
  // AW channel
  output logic              io_master_awvalid,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [3:0]        io_master_awid,
  output logic [7:0]        io_master_awlen,
  output logic [2:0]        io_master_awsize,
  output logic [1:0]        io_master_awburst,
  input  logic              io_master_awready,
  // W channel
  output logic              io_master_wvalid,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [3:0]        io_master_wstrb,
  output logic              io_master_wlast,
  input  logic              io_master_wready,
  // B channel
  output logic              io_master_bready,
  input  logic              io_master_bvalid,
  input  logic [1:0]        io_master_bresp,
  input  logic [3:0]        io_master_bid,
  // AR channel
  output logic              io_master_arvalid,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_arready,
  // R channel
  output logic              io_master_rready,
  input  logic              io_master_rvalid,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic [3:0]        io_master_rid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD
  } state_t;

  // Largest burst the bridge will issue; an out-of-range length is clamped here.
  localparam logic [7:0] LEN_CAP = 8'(MAX_LEN - 1);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_aw_done;
  logic              r_w_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wmask;
  logic [7:0]        r_len;
  logic [7:0]        r_beat_cnt;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_last;
  logic              r_resp_err;

  logic              w_req_fire;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_aw_fin;
  logic              w_w_fin;
  logic              w_beat_final;
  logic [7:0]        w_len_clamped;
  logic              w_unused_ids;

  assign w_req_fire    = req_valid & r_req_ready;
  assign w_aw_hs       = r_awvalid & io_master_awready;
  assign w_w_hs        = r_wvalid & io_master_wready;
  assign w_b_hs        = r_bready & io_master_bvalid;
  assign w_ar_hs       = r_arvalid & io_master_arready;
  assign w_r_hs        = r_rready & io_master_rvalid;
  assign w_aw_fin      = r_aw_done | w_aw_hs;
  assign w_w_fin       = r_w_done | w_w_hs;
  assign w_beat_final  = (r_beat_cnt == 8'd0);
  assign w_len_clamped = (req_len > LEN_CAP) ? LEN_CAP : req_len;
  assign w_unused_ids  = ^{io_master_bid, io_master_rid};

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_last  = r_resp_last;
  assign resp_err   = r_resp_err;

  assign io_master_awvalid = r_awvalid;
  assign io_master_awaddr  = r_addr;
  assign io_master_awid    = 4'(AXI_ID);
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = 3'b010;
  assign io_master_awburst = 2'b01;

  assign io_master_wvalid  = r_wvalid;
  assign io_master_wdata   = r_wdata;
  assign io_master_wstrb   = r_wmask;
  assign io_master_wlast   = 1'b1;

  assign io_master_bready  = r_bready;

  assign io_master_arvalid = r_arvalid;
  assign io_master_araddr  = r_addr;
  assign io_master_arid    = 4'(AXI_ID);
  assign io_master_arlen   = r_len;
  assign io_master_arsize  = 3'b010;
  assign io_master_arburst = 2'b01;

  assign io_master_rready  = r_rready;

  // Transaction FSM: every channel valid/ready and response output is a register driven here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= 4'd0;
      r_len        <= 8'd0;
      r_beat_cnt   <= 8'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wmask     <= req_wmask;
            r_len       <= w_len_clamped;
            r_req_ready <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (req_wen) begin
              r_state   <= S_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_RA;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_state  <= S_WB;
            r_bready <= 1'b1;
          end
        end
        S_WB: begin
          if (w_b_hs) begin
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_last  <= 1'b1;
            r_resp_err   <= (io_master_bresp != 2'b00);
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_RA: begin
          if (w_ar_hs) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_beat_cnt <= r_len;
            r_state    <= S_RD;
          end
        end
        S_RD: begin
          if (w_r_hs) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= io_master_rdata;
            r_resp_last  <= io_master_rlast;
            r_resp_err   <= (io_master_rresp != 2'b00) | (io_master_rlast != w_beat_final);
            if (!w_beat_final) begin
              r_beat_cnt <= r_beat_cnt - 8'd1;
            end
            if (io_master_rlast) begin
              r_rready    <= 1'b0;
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
